instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the instruction address width.
REQ-002 Parameter INSTR_W, default 16, SHALL set the instruction width; opcode occupies bits [INSTR_W-1:INSTR_W-5].
REQ-003 in_clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 in_rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_start  input  1  SHALL be the run request, sampled in IDLE and HALT only.
REQ-006 in_start_addr  input  ADDR_W  SHALL be the first fetch address, loaded into PC on an accepted start.
REQ-007 out_imem_req  output  1  SHALL be the instruction-memory read request.
REQ-008 out_imem_addr  output  ADDR_W  SHALL equal PC.
REQ-009 in_imem_ack  input  1  SHALL indicate that in_imem_data is valid this cycle.
REQ-010 in_imem_data  input  INSTR_W  SHALL be the fetched instruction word.
REQ-011 out_op_code  output  5  SHALL be the IR opcode field, driven to the control unit.
REQ-012 out_instr  output  INSTR_W  SHALL be the IR contents, for operand fields.
REQ-013 in_reg_file_wr_en  input  1  SHALL be the control unit's decoded register-file write enable.
REQ-014 out_wb_en  output  1  SHALL be the gated register-file write strobe.
REQ-015 out_busy  output  1  SHALL be 1 in every state except IDLE and HALT.
REQ-016 out_halted  output  1  SHALL be 1 in HALT.
REQ-017 out_illegal  output  1  SHALL be a one-cycle pulse for an undefined opcode.
REQ-018 out_instr_count  output  16  SHALL count retired instructions.

Function
REQ-019 The FSM SHALL have states IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
REQ-020 IDLE: in_start=1 -> PC<=in_start_addr, out_instr_count<=0, go to FETCH; otherwise stay.
REQ-021 FETCH: out_imem_req=1; with ack=0, stay and hold PC; with ack=1, IR<=in_imem_data at that edge, go to DECODE.
REQ-022 out_imem_req SHALL be 0 in every state except FETCH.
REQ-023 DECODE SHALL last exactly one cycle, then go to EXECUTE.
REQ-024 In DECODE, opcodes 9..30 SHALL pulse out_illegal for one cycle; such instructions retire as no-ops with out_wb_en=0.
REQ-025 In DECODE, opcode 31 SHALL go to HALT instead of EXECUTE; PC is not incremented and the count is not incremented.
REQ-026 EXECUTE SHALL last exactly one cycle, then go to WRITEBACK.
REQ-027 out_wb_en SHALL equal in_reg_file_wr_en in WRITEBACK, for legal opcodes 0..8 only, and SHALL be 0 in every other state.
REQ-028 In WRITEBACK: PC<=PC+1 modulo 2^ADDR_W (all-ones wraps to 0), out_instr_count<=out_instr_count+1 (wraps at 65535->0), go to FETCH.
REQ-029 Minimum throughput: 4 cycles per instruction when ack is returned in the first FETCH cycle.
REQ-030 HALT: hold PC, IR and count; in_start=1 SHALL behave as in IDLE.
REQ-031 An in_imem_ack arriving outside FETCH SHALL be ignored.
REQ-032 in_start asserted while out_busy=1 SHALL be ignored.

Reset
REQ-033 On in_rst_n=0, asynchronously: state<=IDLE, PC<=0, IR<=0, out_instr_count<=0, and all single-bit outputs <=0.
REQ-034 Reset asserted in any state, including a FETCH awaiting ack, SHALL abort the instruction with no write strobe.
REQ-035 After reset deasserts, the first possible transition SHALL be IDLE->FETCH on in_start.

Verification
REQ-036 Reset, then start at addr 0x10 with ack=1 on the first FETCH cycle and instr opcode 1 -> out_wb_en=1 exactly in cycle 4, PC=0x11, count=1.
REQ-037 Hold ack low for 5 cycles in FETCH -> out_imem_req stays 1, addr stays constant, no DECODE until ack.
REQ-038 Opcode 0, then opcode 12 -> out_wb_en=0 for both; out_illegal pulses once for the opcode-12 instruction; count=2.
REQ-039 Start at addr 0xFF with opcode 5 -> next fetch addr is 0x00.
REQ-040 Opcode 31 after 3 legal instructions -> out_halted=1, count=3, PC holds the halt address; in_start=1 -> restart from in_start_addr with count=0.
REQ-041 Assert in_rst_n=0 during EXECUTE -> all outputs 0 immediately, no out_wb_en pulse, state IDLE.

Source files
------------

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//   Multi-cycle instruction sequencer: FETCH -> DECODE -> EXECUTE -> WRITEBACK,
//   with IDLE before the first start and HALT after a halt opcode (31).
//   Opcodes 0..8 are legal, 9..30 retire as no-ops with an illegal pulse.
//
// Ports
//   in_clk, in_rst_n        clock, async active-low reset
//   in_start, in_start_addr run request (IDLE/HALT only) and first fetch address
//   out_imem_req/addr       instruction fetch request, address = PC
//   in_imem_ack/data        fetch response (ignored outside FETCH)
//   out_op_code, out_instr  IR opcode field and full IR
//   in_reg_file_wr_en       decoded write enable from the control unit
//   out_wb_en               gated register-file write strobe (WRITEBACK only)
//   out_busy, out_halted    status
//   out_illegal             one-cycle pulse in DECODE for opcodes 9..30
//   out_instr_count         retired-instruction counter
// -----------------------------------------------------------------------------
module instr_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               in_clk,
    input  logic               in_rst_n,
    input  logic               in_start,
    input  logic [ADDR_W-1:0]  in_start_addr,
    output logic               out_imem_req,
    output logic [ADDR_W-1:0]  out_imem_addr,
    input  logic               in_imem_ack,
    input  logic [INSTR_W-1:0] in_imem_data,
    output logic [4:0]         out_op_code,
    output logic [INSTR_W-1:0] out_instr,
    input  logic               in_reg_file_wr_en,
    output logic               out_wb_en,
    output logic               out_busy,
    output logic               out_halted,
    output logic               out_illegal,
    output logic [15:0]        out_instr_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_DEC   = 3'd2;
    localparam logic [2:0] S_EXE   = 3'd3;
    localparam logic [2:0] S_WB    = 3'd4;
    localparam logic [2:0] S_HALT  = 3'd5;

    logic [2:0]         r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic [15:0]        r_count;

    logic [4:0] w_op;
    logic       w_legal;
    logic       w_halt_op;
    logic       w_idle_like;

    assign w_op        = r_ir[INSTR_W-1 -: 5];
    assign w_legal     = (w_op <= 5'd8);
    assign w_halt_op   = (w_op == 5'd31);
    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_HALT);

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (in_start) begin
                        r_pc    <= in_start_addr;
                        r_count <= '0;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (in_imem_ack) begin
                        r_ir    <= in_imem_data;
                        r_state <= S_DEC;
                    end
                end
                // Halt opcode leaves PC on the halt address and does not retire.
                S_DEC:   r_state <= w_halt_op ? S_HALT : S_EXE;
                S_EXE:   r_state <= S_WB;
                S_WB: begin
                    r_pc    <= r_pc + 1'b1;
                    r_count <= r_count + 1'b1;
                    r_state <= S_FETCH;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Status/strobe outputs decode straight from state so reset forces them
    // low immediately, with no registered strobe left in flight.
    assign out_imem_req    = (r_state == S_FETCH);
    assign out_imem_addr   = r_pc;
    assign out_op_code     = w_op;
    assign out_instr       = r_ir;
    assign out_wb_en       = (r_state == S_WB) && w_legal && in_reg_file_wr_en;
    assign out_busy        = !w_idle_like;
    assign out_halted      = (r_state == S_HALT);
    assign out_illegal     = (r_state == S_DEC) && !w_legal && !w_halt_op;
    assign out_instr_count = r_count;

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

  logic        in_clk;
  logic        in_rst_n;
  logic        in_start;
  logic [7:0]  in_start_addr;
  logic        out_imem_req;
  logic [7:0]  out_imem_addr;
  logic        in_imem_ack;
  logic [15:0] in_imem_data;
  logic [4:0]  out_op_code;
  logic [15:0] out_instr;
  logic        in_reg_file_wr_en;
  logic        out_wb_en;
  logic        out_busy;
  logic        out_halted;
  logic        out_illegal;
  logic [15:0] out_instr_count;

  instr_sequencer #(.ADDR_W(8), .INSTR_W(16)) dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_start(in_start),
    .in_start_addr(in_start_addr), .out_imem_req(out_imem_req),
    .out_imem_addr(out_imem_addr), .in_imem_ack(in_imem_ack),
    .in_imem_data(in_imem_data), .out_op_code(out_op_code),
    .out_instr(out_instr), .in_reg_file_wr_en(in_reg_file_wr_en),
    .out_wb_en(out_wb_en), .out_busy(out_busy), .out_halted(out_halted),
    .out_illegal(out_illegal), .out_instr_count(out_instr_count)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory and a responder with a programmable ack latency.
  logic [15:0] mem [256];
  int  ack_delay = 0;
  int  waited    = 0;
  bit  stray     = 0;   // drive ack with a halt word while no fetch is pending

  function automatic logic [15:0] mk(input logic [4:0] op);
    return {op, 11'h155};
  endfunction

  // Control unit stand-in: opcode 0 is a NOP with no register write.
  assign in_reg_file_wr_en = (out_op_code != 5'd0);

  always @(negedge in_clk) begin
    if (out_imem_req) begin
      if (waited >= ack_delay) begin
        in_imem_ack  = 1'b1;
        in_imem_data = mem[out_imem_addr];
        waited = 0;
      end else begin
        in_imem_ack  = 1'b0;
        in_imem_data = 16'($urandom);
        waited++;
      end
    end else begin
      in_imem_ack  = stray;
      in_imem_data = 16'hFFFF;
      waited = 0;
    end
  end

  // Reference model: a running instruction walks through four steps
  // (fetch / decode / execute / writeback); fetch repeats until acked.
  int          m_mode = 0;   // 0 idle, 1 running, 2 halted
  int          m_step = 0;
  logic [7:0]  m_pc   = '0;
  logic [15:0] m_ir   = '0;
  logic [15:0] m_cnt  = '0;

  initial forever begin
    @(posedge in_clk or negedge in_rst_n);
    if (!in_rst_n) begin
      m_mode = 0; m_step = 0; m_pc = '0; m_ir = '0; m_cnt = '0;
    end else if (m_mode != 1) begin
      if (in_start) begin
        m_mode = 1; m_step = 0; m_pc = in_start_addr; m_cnt = '0;
      end
    end else begin
      if (m_step == 0) begin
        if (in_imem_ack) begin m_ir = in_imem_data; m_step = 1; end
      end else if (m_step == 1) begin
        if (m_ir[15:11] == 5'd31) m_mode = 2;
        else m_step = 2;
      end else if (m_step == 2) begin
        m_step = 3;
      end else begin
        m_pc  = m_pc + 8'd1;
        m_cnt = m_cnt + 16'd1;
        m_step = 0;
      end
    end
  end

  int wb_seen  = 0;
  int ill_seen = 0;

  initial forever begin
    logic [4:0] op;
    @(posedge in_clk);
    #1;
    op = m_ir[15:11];
    chk("req",    32'(out_imem_req),    32'(m_mode == 1 && m_step == 0));
    chk("addr",   32'(out_imem_addr),   32'(m_pc));
    chk("instr",  32'(out_instr),       32'(m_ir));
    chk("opcode", 32'(out_op_code),     32'(op));
    chk("wb_en",  32'(out_wb_en),       32'(m_mode == 1 && m_step == 3 && op <= 8 && in_reg_file_wr_en));
    chk("busy",   32'(out_busy),        32'(m_mode == 1));
    chk("halted", 32'(out_halted),      32'(m_mode == 2));
    chk("illegal",32'(out_illegal),     32'(m_mode == 1 && m_step == 1 && op >= 9 && op <= 30));
    chk("count",  32'(out_instr_count), 32'(m_cnt));
    if (out_wb_en)   wb_seen++;
    if (out_illegal) ill_seen++;
  end

  task automatic do_start(input logic [7:0] a);
    @(negedge in_clk);
    in_start = 1'b1; in_start_addr = a;
    @(negedge in_clk);
    in_start = 1'b0;
  endtask

  task automatic wait_halt();
    int n = 0;
    while (!out_halted && n < 300) begin
      @(posedge in_clk); #2; n++;
    end
    chk("halt_reached", 32'(out_halted), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = mk(5'd31);
    in_rst_n = 1'b0; in_start = 1'b0; in_start_addr = '0;
    in_imem_ack = 1'b0; in_imem_data = '0;
    repeat (3) @(negedge in_clk);
    chk("rst_busy",  32'(out_busy), 32'd0);
    chk("rst_req",   32'(out_imem_req), 32'd0);
    chk("rst_count", 32'(out_instr_count), 32'd0);
    chk("rst_addr",  32'(out_imem_addr), 32'd0);
    in_rst_n = 1'b1;
    repeat (2) @(negedge in_clk);
    chk("idle_stays", 32'(out_busy), 32'd0);

    // First instruction: writeback strobe in the 4th cycle after entering FETCH.
    mem[8'h10] = mk(5'd1);
    do_start(8'h10);
    repeat (3) @(posedge in_clk);
    #2 chk("t1_wb_cycle4", 32'(out_wb_en), 32'd1);
    @(posedge in_clk);
    #2 chk("t1_pc", 32'(out_imem_addr), 32'h11);
    chk("t1_count", 32'(out_instr_count), 32'd1);
    wait_halt();

    // Slow memory: request and address hold while ack is low.
    ack_delay = 5;
    mem[8'h20] = mk(5'd1);
    do_start(8'h20);
    for (int i = 0; i < 5; i++) begin
      @(posedge in_clk); #2;
      chk("t2_req_hold",  32'(out_imem_req), 32'd1);
      chk("t2_addr_hold", 32'(out_imem_addr), 32'h20);
      chk("t2_no_decode", 32'(out_op_code), 32'd31);
    end
    wait_halt();
    chk("t2_count", 32'(out_instr_count), 32'd1);
    ack_delay = 0;

    // NOP then illegal opcode; stray acks and a start while busy are ignored.
    stray = 1;
    mem[8'h30] = mk(5'd0);
    mem[8'h31] = mk(5'd12);
    wb_seen = 0; ill_seen = 0;
    do_start(8'h30);
    repeat (2) @(negedge in_clk);
    in_start = 1'b1; in_start_addr = 8'h77;
    @(negedge in_clk);
    in_start = 1'b0;
    wait_halt();
    chk("t3_illegal_pulses", 32'(ill_seen), 32'd1);
    chk("t3_no_wb", 32'(wb_seen), 32'd0);
    chk("t3_count", 32'(out_instr_count), 32'd2);
    chk("t3_halt_addr", 32'(out_imem_addr), 32'h32);
    stray = 0;

    // PC wraps from 0xFF to 0x00.
    mem[8'hFF] = mk(5'd5);
    wb_seen = 0;
    do_start(8'hFF);
    wait_halt();
    chk("t4_wrap_addr", 32'(out_imem_addr), 32'h00);
    chk("t4_count", 32'(out_instr_count), 32'd1);
    chk("t4_wb", 32'(wb_seen), 32'd1);

    // Three legal instructions then halt; restart from HALT clears the count.
    mem[8'h40] = mk(5'd1);
    mem[8'h41] = mk(5'd2);
    mem[8'h42] = mk(5'd3);
    do_start(8'h40);
    wait_halt();
    chk("t5_count", 32'(out_instr_count), 32'd3);
    chk("t5_halt_addr", 32'(out_imem_addr), 32'h43);
    repeat (3) @(negedge in_clk);
    chk("t5_hold_addr", 32'(out_imem_addr), 32'h43);
    do_start(8'h50);
    chk("t5_restart_count", 32'(out_instr_count), 32'd0);
    chk("t5_restart_addr", 32'(out_imem_addr), 32'h50);
    chk("t5_restart_busy", 32'(out_busy), 32'd1);
    wait_halt();

    // Reset during EXECUTE aborts with no write strobe.
    mem[8'h60] = mk(5'd1);
    wb_seen = 0;
    do_start(8'h60);
    @(posedge in_clk);
    @(posedge in_clk);
    @(negedge in_clk);
    in_rst_n = 1'b0;
    #1;
    chk("t6_busy",   32'(out_busy), 32'd0);
    chk("t6_wb",     32'(out_wb_en), 32'd0);
    chk("t6_req",    32'(out_imem_req), 32'd0);
    chk("t6_addr",   32'(out_imem_addr), 32'd0);
    chk("t6_instr",  32'(out_instr), 32'd0);
    chk("t6_count",  32'(out_instr_count), 32'd0);
    chk("t6_halted", 32'(out_halted), 32'd0);
    repeat (3) @(negedge in_clk);
    in_rst_n = 1'b1;
    repeat (3) @(posedge in_clk);
    #2 chk("t6_idle_after", 32'(out_busy), 32'd0);
    chk("t6_no_wb_pulse", 32'(wb_seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
